// File: rtl/mem_io_responder_if.sv
// rtl/mem_io_responder_if.sv - CPU data bus plus TX/RX stream signals of the memory responder
interface mem_io_responder_if #(
  parameter int WordSize    = 16,
  parameter int MemAddrSize = 15
);
  logic                   writeM;
  logic [MemAddrSize-1:0] addressM;
  logic [WordSize-1:0]    outM;
  logic [WordSize-1:0]    inM;
  logic [WordSize-1:0]    tx_data;
  logic                   tx_valid;
  logic                   tx_ready;
  logic [WordSize-1:0]    rx_data;
  logic                   rx_valid;
  logic                   rx_ready;

  // CPU and external stream endpoints drive the bus
  modport master (
    output writeM, addressM, outM, tx_ready, rx_data, rx_valid,
    input  inM, tx_data, tx_valid, rx_ready
  );

  // the responder answers it
  modport slave (
    input  writeM, addressM, outM, tx_ready, rx_data, rx_valid,
    output inM, tx_data, tx_valid, rx_ready
  );
endinterface

// File: rtl/mem_io_responder.sv
// rtl/mem_io_responder.sv - data RAM plus memory-mapped TX FIFO and RX holding register
module mem_io_responder #(
  parameter int WordSize      = 16,
  parameter int MemAddrSize   = 15,
  parameter int RamAddrBits   = 14,
  parameter int FifoDepthLog2 = 3
) (
  input logic              clk,
  input logic              reset,
  mem_io_responder_if.slave bus
);
  localparam int Depth = 2 ** FifoDepthLog2;
  localparam logic [MemAddrSize-1:0] AddrTx     = MemAddrSize'(2 ** RamAddrBits);
  localparam logic [MemAddrSize-1:0] AddrStatus = MemAddrSize'(2 ** RamAddrBits + 1);
  localparam logic [MemAddrSize-1:0] AddrRx     = MemAddrSize'(2 ** RamAddrBits + 2);
  localparam logic [MemAddrSize-1:0] AddrRxAck  = MemAddrSize'(2 ** RamAddrBits + 3);

  logic [WordSize-1:0] mem      [2 ** RamAddrBits];
  logic [WordSize-1:0] fifo_mem [Depth];

  logic [FifoDepthLog2-1:0] rd_ptr;
  logic [FifoDepthLog2-1:0] wr_ptr;
  logic [FifoDepthLog2:0]   count;
  logic                     tx_overflow;
  logic                     rx_full;
  logic [WordSize-1:0]      rx_hold;

  logic                is_ram;
  logic                tx_full;
  logic                tx_empty;
  logic                push;
  logic                push_ok;
  logic                pop;
  logic                ovf_clear;
  logic                rx_ack;
  logic                rx_capture;
  logic [WordSize-1:0] status;

  assign is_ram     = bus.addressM < AddrTx;
  assign tx_full    = count == (FifoDepthLog2 + 1)'(Depth);
  assign tx_empty   = count == '0;
  assign push       = bus.writeM & (bus.addressM == AddrTx);
  // fullness is judged before the edge, so a same-cycle pop never makes room
  assign push_ok    = push & ~tx_full;
  assign pop        = ~tx_empty & bus.tx_ready;
  assign ovf_clear  = bus.writeM & (bus.addressM == AddrStatus) & bus.outM[3];
  assign rx_ack     = bus.writeM & (bus.addressM == AddrRxAck);
  assign rx_capture = bus.rx_valid & bus.rx_ready;

  assign bus.tx_valid = ~tx_empty;
  assign bus.tx_data  = fifo_mem[rd_ptr];
  assign bus.rx_ready = ~rx_full & ~reset;

  // data RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (bus.writeM && is_ram) begin
      mem[bus.addressM[RamAddrBits-1:0]] <= bus.outM;
    end
  end

  // TX FIFO storage; only accepted pushes land in the buffer
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= bus.outM;
    end
  end

  // TX FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      tx_overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && tx_full)  tx_overflow <= 1'b1;
      else if (ovf_clear)   tx_overflow <= 1'b0;
    end
  end

  // RX holding register; an ack and a capture can never coincide since capture needs it empty
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_full <= 1'b0;
      rx_hold <= '0;
    end else if (rx_ack && rx_full) begin
      rx_full <= 1'b0;
    end else if (rx_capture) begin
      rx_full <= 1'b1;
      rx_hold <= bus.rx_data;
    end
  end

  // status word layout: count above four flag bits
  always_comb begin
    status = '0;
    status[FifoDepthLog2+4:4] = count;
    status[3] = tx_overflow;
    status[2] = rx_full;
    status[1] = tx_empty;
    status[0] = tx_full;
  end

  // read mux back to the CPU, no added cycle
  always_comb begin
    bus.inM = '0;
    if (is_ram) begin
      bus.inM = mem[bus.addressM[RamAddrBits-1:0]];
    end else if (bus.addressM == AddrStatus) begin
      bus.inM = status;
    end else if (bus.addressM == AddrRx) begin
      bus.inM = rx_full ? rx_hold : '0;
    end
  end
endmodule

// File: tb/tb_mem_io_responder.sv
// tb/tb_mem_io_responder.sv - directed self-checking bench for mem_io_responder
module tb_mem_io_responder;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  localparam logic [14:0] A_TX  = 15'h4000;
  localparam logic [14:0] A_ST  = 15'h4001;
  localparam logic [14:0] A_RX  = 15'h4002;
  localparam logic [14:0] A_ACK = 15'h4003;

  always #10 clk = ~clk;

  mem_io_responder_if #(.WordSize(16), .MemAddrSize(15)) bus ();

  mem_io_responder #(
    .WordSize(16), .MemAddrSize(15), .RamAddrBits(14), .FifoDepthLog2(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [14:0] addr, input logic [15:0] data);
    bus.writeM   = 1'b1;
    bus.addressM = addr;
    bus.outM     = data;
    tick();
    bus.writeM   = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [14:0] addr, input logic [15:0] exp);
    bus.addressM = addr;
    #1;
    check(tag, bus.inM, exp);
  endtask

  initial begin
    reset        = 1'b1;
    bus.writeM   = 1'b0;
    bus.addressM = '0;
    bus.outM     = '0;
    bus.tx_ready = 1'b0;
    bus.rx_data  = '0;
    bus.rx_valid = 1'b0;

    #3;
    check("rst_tx_valid", bus.tx_valid, 0);
    check("rst_rx_ready", bus.rx_ready, 0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("post_rst_rx_ready", bus.rx_ready, 1);
    check("post_rst_tx_valid", bus.tx_valid, 0);
    rd("post_rst_status", A_ST, 16'h0002);

    wr(15'd5, 16'h1234);
    rd("ram5", 15'd5, 16'h1234);
    rd("io_unmapped", 15'h4005, 16'h0000);
    wr(15'd6, 16'h1111);
    bus.writeM   = 1'b1;
    bus.addressM = 15'd6;
    bus.outM     = 16'h2222;
    #1;
    check("ram_old_during_write", bus.inM, 16'h1111);
    tick();
    bus.writeM = 1'b0;
    rd("ram_new", 15'd6, 16'h2222);

    for (int i = 0; i < 8; i++) wr(A_TX, 16'hA001 + 16'(i));
    rd("status_full", A_ST, 16'h0081);
    check("tx_head", bus.tx_data, 16'hA001);
    wr(A_TX, 16'hA009);
    rd("status_overflow", A_ST, 16'h0089);
    rd("txdata_read_zero", A_TX, 16'h0000);
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain_valid", bus.tx_valid, 1);
      check("drain_data", bus.tx_data, 16'hA001 + 16'(i));
      tick();
    end
    bus.tx_ready = 1'b0;
    check("drained_valid", bus.tx_valid, 0);
    rd("status_drained", A_ST, 16'h000A);
    wr(A_ST, 16'h0008);
    rd("status_ovf_cleared", A_ST, 16'h0002);

    for (int i = 0; i < 8; i++) wr(A_TX, 16'hB001 + 16'(i));
    bus.writeM   = 1'b1;
    bus.addressM = A_TX;
    bus.outM     = 16'hB009;
    bus.tx_ready = 1'b1;
    tick();
    bus.writeM   = 1'b0;
    bus.tx_ready = 1'b0;
    rd("status_full_pushpop", A_ST, 16'h0078);
    wr(A_ST, 16'hFFF7);
    rd("status_clear_ignored", A_ST, 16'h0078);
    wr(A_ST, 16'h0008);
    rd("status_clear", A_ST, 16'h0070);
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      check("full_pp_data", bus.tx_data, 16'hB002 + 16'(i));
      tick();
    end
    bus.tx_ready = 1'b0;
    check("full_pp_empty", bus.tx_valid, 0);

    wr(A_TX, 16'hC000);
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.writeM   = 1'b1;
      bus.addressM = A_TX;
      bus.outM     = 16'hC001 + 16'(i);
      check("stream_data", bus.tx_data, 16'hC000 + 16'(i));
      tick();
    end
    bus.writeM = 1'b0;
    check("stream_last", bus.tx_data, 16'hC005);
    rd("stream_count1", A_ST, 16'h0010);
    tick();
    bus.tx_ready = 1'b0;
    rd("stream_done", A_ST, 16'h0002);

    for (int i = 0; i < 20; i++) begin
      wr(A_TX, 16'hD000 + 16'(i));
      bus.tx_ready = 1'b1;
      check("wrap_data", bus.tx_data, 16'hD000 + 16'(i));
      tick();
      bus.tx_ready = 1'b0;
    end
    rd("wrap_status", A_ST, 16'h0002);
    check("wrap_valid", bus.tx_valid, 0);

    bus.addressM = A_RX;
    bus.rx_data  = 16'hBEEF;
    bus.rx_valid = 1'b1;
    #1;
    check("rx_ready_free", bus.rx_ready, 1);
    tick();
    check("rx_ready_held", bus.rx_ready, 0);
    rd("rxdata_beef", A_RX, 16'hBEEF);
    rd("status_rx_full", A_ST, 16'h0006);
    bus.rx_data = 16'hCAFE;
    tick();
    rd("rxdata_still_beef", A_RX, 16'hBEEF);
    wr(A_ACK, 16'h0000);
    check("rx_ready_after_ack", bus.rx_ready, 1);
    rd("rxdata_empty", A_RX, 16'h0000);
    tick();
    bus.rx_valid = 1'b0;
    rd("rxdata_cafe", A_RX, 16'hCAFE);
    rd("rxack_read_zero", A_ACK, 16'h0000);

    for (int i = 0; i < 3; i++) wr(A_TX, 16'hE001 + 16'(i));
    check("pre_rst_valid", bus.tx_valid, 1);
    rd("pre_rst_status", A_ST, 16'h0034);
    reset = 1'b1;
    #1;
    check("mid_rst_tx_valid", bus.tx_valid, 0);
    check("mid_rst_rx_ready", bus.rx_ready, 0);
    rd("mid_rst_status", A_ST, 16'h0002);
    rd("mid_rst_rxdata", A_RX, 16'h0000);
    tick();
    reset = 1'b0;
    #1;
    check("rel_rx_ready", bus.rx_ready, 1);
    check("rel_tx_valid", bus.tx_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mem_io_responder.md
# mem_io_responder

Memory-side responder for the CPU data bus: consumes the CPU's `writeM`/`addressM`/`outM` outputs and returns `inM`. It contains the data RAM and a small memory-mapped I/O block: a transmit FIFO that drains to an external valid/ready stream, and a one-word receive holding register fed from an external valid/ready stream. It sits between the CPU and the outside world in the top level, next to the instruction ROM.

## Interface
Parameters:
- `WordSize`, 16, data word width (matches CPU)
- `MemAddrSize`, 15, width of `addressM`
- `RamAddrBits`, 14, RAM holds 2^RamAddrBits words at addresses 0 .. 2^RamAddrBits-1
- `FifoDepthLog2`, 3, TX FIFO depth = 2^FifoDepthLog2 words

Ports:
- `clk`  in  1  system clock, all state updates on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `writeM`  in  1  CPU write strobe, sampled at posedge
- `addressM`  in  MemAddrSize  CPU data address
- `outM`  in  WordSize  CPU write data
- `inM`  out  WordSize  read data to CPU, combinational from `addressM`
- `tx_data`  out  WordSize  head of TX FIFO
- `tx_valid`  out  1  TX FIFO non-empty
- `tx_ready`  in  1  sink accepts `tx_data` at posedge when `tx_valid` is high
- `rx_data`  in  WordSize  incoming word
- `rx_valid`  in  1  source offers `rx_data`
- `rx_ready`  out  1  holding register free

## Operation
Address map. Let IO = 2^RamAddrBits (0x4000 at defaults):
- 0 .. IO-1: RAM. Write: `mem[addressM] <= outM` when `writeM`. Read: `inM = mem[addressM]`.
- IO+0 TXDATA: write pushes `outM` into the FIFO. Read returns 0.
- IO+1 STATUS: read = {zero-pad, count[FifoDepthLog2:0] at bits [FifoDepthLog2+4:4], bit3 tx_overflow, bit2 rx_full, bit1 tx_empty, bit0 tx_full}. A write with `outM[3]`=1 clears tx_overflow; other bits are ignored.
- IO+2 RXDATA: read = held word when rx_full, else 0. Reads have no side effects.
- IO+3 RXACK: a write of any value clears rx_full. Read returns 0.
- IO+4 and above: read returns 0, write ignored.

TX FIFO: circular buffer with read/write pointers of FifoDepthLog2 bits (wrap modulo depth), plus a count of FifoDepthLog2+1 bits.
- push = TXDATA write; pop = `tx_valid & tx_ready`
- Push when full: word dropped, tx_overflow set (sticky), count unchanged. Applies even if a pop occurs in the same cycle; fullness is evaluated before the edge.
- Push and pop in the same cycle, not full and not empty: count unchanged, both pointers advance.
- Push when empty: no pop is possible (`tx_valid`=0), so count becomes 1.
- `tx_data` = buffer[rd_ptr]. Its value is don't-care when empty.
- tx_overflow set and clear in the same cycle: set wins.

RX holding register:
- `rx_ready = ~rx_full & ~reset`
- At posedge, `rx_valid & rx_ready` captures `rx_data` and sets rx_full.
- RXACK while rx_full clears rx_full. No capture occurs that cycle because `rx_ready` was 0; the next word can be captured on the following edge at the earliest.
- RXACK while empty: no effect.

## Timing
- Reset (async): FIFO pointers and count = 0, tx_overflow = 0, rx_full = 0. Results: `tx_valid`=0, `rx_ready`=0 while reset is held and 1 after release, `inM` follows the map. RAM contents are not reset.
- Reset mid-operation: queued TX words and the held RX word are discarded immediately. No handshake completes while reset is high.
- Write latency: a write at edge N is visible on `inM` and on status immediately after edge N. Same-address read during the write cycle returns the old value.
- TX: a push at edge N raises `tx_valid` after edge N. One pop per edge at most. Throughput is 1 word/cycle.
- RX: a capture at edge N makes rx_full and RXDATA visible after edge N, and `rx_ready` falls after edge N.
- `inM` is purely combinational from `addressM` and state, with no added cycle.

## Test plan
- Reset, then write 0x1234 to RAM[5], then read address 5 -> `inM`=0x1234; read 0x4005 -> 0; after reset, `tx_valid`=0 and `rx_ready`=1.
- Push 0xA001..0xA008 with `tx_ready`=0 -> STATUS=0x0081 (count 8, full). Ninth push 0xA009 -> STATUS bit3 set. Raise `tx_ready` -> `tx_data` sequence A001..A008, with no A009; then `tx_valid`=0 and STATUS=0x000A.
- With FIFO full, push and pop in the same cycle -> pushed word dropped, overflow set, count=7. Write 0x0008 to STATUS -> bit3 clears.
- Drive `rx_data`=0xBEEF with `rx_valid`=1 -> captured, `rx_ready`=0, RXDATA=0xBEEF, STATUS bit2=1. Present 0xCAFE -> held until an RXACK write; 0xCAFE is captured one edge after the ack.
- Wrap-around: 20 interleaved single push/pop pairs -> output order matches input and count returns to 0.
- Assert `reset` with 3 words queued and rx_full=1 -> `tx_valid` and rx_full drop immediately, without waiting for a clock edge.
